// File: rtl/vga_timing_pkg.sv
// VGA timing constants and helpers.
// Shared by the axis counters and the raster generator top.
package vga_timing_pkg;

  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FP      = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BP      = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FP      = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BP      = 33;

  localparam int VGA800_H_VISIBLE = 800;
  localparam int VGA800_H_FP      = 56;
  localparam int VGA800_H_SYNC    = 120;
  localparam int VGA800_H_BP      = 64;
  localparam int VGA800_V_VISIBLE = 600;
  localparam int VGA800_V_FP      = 37;
  localparam int VGA800_V_SYNC    = 6;
  localparam int VGA800_V_BP      = 23;

  function automatic int vga_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus next-state decode.
// Instanced once for horizontal, once for vertical.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FP      = 16,
  parameter int SYNC    = 96,
  parameter int BP      = 48,
  parameter int CW      = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          step_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_next_o,
  output logic          wrap_o,
  output logic          sync_next_o,
  output logic          vis_next_o
);

  localparam int TOTAL = vga_total(VISIBLE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] VIS_N  = CW'(VISIBLE);
  localparam logic [CW-1:0] SYN_LO = CW'(VISIBLE + FP);
  localparam logic [CW-1:0] SYN_HI = CW'(VISIBLE + FP + SYNC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Advance on step, wrapping at the last position of the axis.
  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_next_o  = cnt_d;
  assign wrap_o      = step_i && (cnt_q == LAST);
  assign sync_next_o = (cnt_d >= SYN_LO) && (cnt_d <= SYN_HI);
  assign vis_next_o  = (cnt_d < VIS_N);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel divider.
// Optional frame counter: define VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = VGA640_H_VISIBLE,
  parameter int   H_FP      = VGA640_H_FP,
  parameter int   H_SYNC    = VGA640_H_SYNC,
  parameter int   H_BP      = VGA640_H_BP,
  parameter int   V_VISIBLE = VGA640_V_VISIBLE,
  parameter int   V_FP      = VGA640_V_FP,
  parameter int   V_SYNC    = VGA640_V_SYNC,
  parameter int   V_BP      = VGA640_V_BP,
  parameter int   DIV       = 4,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_nx, v_nx;
  logic          h_wrap, v_wrap;
  logic          h_sync_nx, v_sync_nx;
  logic          h_vis_nx, v_vis_nx;
  logic          hs_q, vs_q, von_q;
  logic          ls_q, fs_q;

  assign p_tick = en && (div_q == DIV_LAST);

  // Pixel divider: counts enabled clocks, restarts after each tick.
  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = p_tick ? '0 : div_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .CW      (CW)
  ) u_h (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .step_i      (p_tick),
    .cnt_o       (x),
    .cnt_next_o  (h_nx),
    .wrap_o      (h_wrap),
    .sync_next_o (h_sync_nx),
    .vis_next_o  (h_vis_nx)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .CW      (CW)
  ) u_v (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .step_i      (h_wrap),
    .cnt_o       (y),
    .cnt_next_o  (v_nx),
    .wrap_o      (v_wrap),
    .sync_next_o (v_sync_nx),
    .vis_next_o  (v_vis_nx)
  );

  // Lookahead counts are exported for renderers; unused here.
  logic unused_nx;
  assign unused_nx = ^{h_nx, v_nx};

  // Decode registered from next-state position so it stays aligned with x/y.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      von_q <= 1'b1;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (en) begin
      hs_q  <= h_sync_nx ? HS_POL : ~HS_POL;
      vs_q  <= v_sync_nx ? VS_POL : ~VS_POL;
      von_q <= h_vis_nx && v_vis_nx;
      ls_q  <= h_wrap;
      fs_q  <= v_wrap;
    end else begin
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_q;

  // Completed-frame count, bumped alongside frame_start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fc_q <= '0;
    end else if (en && v_wrap) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster.
// Reference derives outputs from the enabled-clock count since reset.
module tb_vga_timing_gen;

  localparam int DIV = 3;
  localparam int HV  = 8;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 2;
  localparam int VV  = 5;
  localparam int VF  = 1;
  localparam int VSW = 2;
  localparam int VB  = 1;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int CW  = 5;

  logic          clk;
  logic          reset_n;
  logic          en;
  logic          p_tick;
  logic [CW-1:0] x, y;
  logic          hsync, vsync, video_on;
  logic          line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  vga_timing_gen #(
    .H_VISIBLE (HV),
    .H_FP      (HF),
    .H_SYNC    (HSW),
    .H_BP      (HB),
    .V_VISIBLE (VV),
    .V_FP      (VF),
    .V_SYNC    (VSW),
    .V_BP      (VB),
    .DIV       (DIV),
    .HS_POL    (HP),
    .VS_POL    (VP),
    .CW        (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .p_tick      (p_tick),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: n = enabled clocks since reset; ticks = n / DIV.
  longint n = 0;
  bit     live = 0;
  bit     ls_e = 0;
  bit     fs_e = 0;

  always @(posedge clk) begin
    longint k;
    bit tick;
    if (!reset_n) begin
      n = 0; ls_e = 0; fs_e = 0; live = 1;
    end else if (en) begin
      tick = (n % DIV) == DIV - 1;
      n = n + 1;
      k = n / DIV;
      ls_e = tick && (k % HT == 0);
      fs_e = ls_e && ((k / HT) % VT == 0);
    end else begin
      ls_e = 0; fs_e = 0;
    end
  end

  always @(negedge clk) begin
    longint k;
    int ex, ey;
    bit hs_act, vs_act;
    if (live) begin
      k  = n / DIV;
      ex = int'(k % HT);
      ey = int'((k / HT) % VT);
      hs_act = (ex >= HV + HF) && (ex < HV + HF + HSW);
      vs_act = (ey >= VV + VF) && (ey < VV + VF + VSW);
      chk("p_tick", 32'(p_tick), 32'(en && ((n % DIV) == DIV - 1)));
      chk("x", 32'(x), 32'(ex));
      chk("y", 32'(y), 32'(ey));
      chk("hsync", 32'(hsync), 32'(hs_act ? HP : !HP));
      chk("vsync", 32'(vsync), 32'(vs_act ? VP : !VP));
      chk("video_on", 32'(video_on), 32'((ex < HV) && (ey < VV)));
      chk("line_start", 32'(line_start), 32'(ls_e));
      chk("frame_start", 32'(frame_start), 32'(fs_e));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'((k / (HT * VT)) % 65536));
`endif
    end
  end

  initial begin
    en = 1'b1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_video_on", 32'(video_on), 32'd1);
    chk("rst_line_start", 32'(line_start), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("lit_x10", 32'(x), 32'd10);
    chk("lit_hsync_on", 32'(hsync), 32'd1);
    chk("lit_video_off", 32'(video_on), 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("lit_wrap_x", 32'(x), 32'd0);
    chk("lit_wrap_y", 32'(y), 32'd1);
    chk("lit_line_start", 32'(line_start), 32'd1);
    chk("lit_frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_p_tick", 32'(p_tick), 32'd1);
    chk("lit_hold_x", 32'(x), 32'd0);
    // Freeze mid-divide for 5 clocks.
    @(posedge clk);
    #2 en = 1'b0;
    repeat (5) @(posedge clk);
    #2 en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      en = ($urandom_range(0, 99) >= 12);
      reset_n = ($urandom_range(0, 1999) != 0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
